// File: rtl/sw_event_pkg.sv
//------------------------------------------------------------------------------
// Module : sw_event_pkg
// Brief  : Shared defaults, event-entry field layout and FSM encoding.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package sw_event_pkg;

    localparam int c_nsw_default   = 2;
    localparam int c_depth_default = 4;
    localparam int c_ts_w_default  = 16;

    localparam int c_entry_w    = 32;
    localparam int c_lvl_lsb    = 0;
    localparam int c_rise_lsb   = 2;
    localparam int c_fall_lsb   = 4;
    localparam int c_ts_lsb     = 16;
    localparam int c_ts_field_w = 16;

    typedef enum logic [0:0] {
        S_PRIME = 1'b0,
        S_RUN   = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/evt_fifo.sv
//------------------------------------------------------------------------------
// Module : evt_fifo
// Brief  : Synchronous show-ahead FIFO; push into a full FIFO is accepted only
//          when a pop is accepted in the same cycle.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] c_ptr_one  = 1;
    localparam logic [AW:0]   c_cnt_one  = 1;
    localparam logic [AW:0]   c_cnt_full = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_cnt_full);
    assign count     = r_count;
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);
    assign rd_data   = empty ? '0 : r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule

`default_nettype wire

// File: rtl/sw_event_queue.sv
//------------------------------------------------------------------------------
// Module : sw_event_queue
// Brief  : Timestamped switch-edge event queue with sticky overflow and IRQ.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module sw_event_queue
    import sw_event_pkg::*;
#(
    parameter int NSW   = c_nsw_default,
    parameter int DEPTH = c_depth_default,
    parameter int TS_W  = c_ts_w_default
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NSW-1:0]             sw_db,
    input  logic                       pop,
    input  logic                       clr_ovf,
    input  logic                       irq_en,
    output logic                       evt_valid,
    output logic [c_entry_w-1:0]       evt_data,
    output logic [$clog2(DEPTH):0]     evt_count,
    output logic                       overflow,
    output logic                       fabint
);

    localparam logic [TS_W-1:0] c_ts_one = 1;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [TS_W-1:0]           r_ts;
    logic [NSW-1:0]            r_sw_prev;
    logic [NSW-1:0]            w_rise;
    logic [NSW-1:0]            w_fall;
    logic [c_ts_field_w-1:0]   w_ts_field;
    logic [c_entry_w-1:0]      w_entry;
    logic                      w_push;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_drop;
    logic                      r_overflow;
    logic                      r_fabint;

    assign w_rise     = sw_db & ~r_sw_prev;
    assign w_fall     = ~sw_db & r_sw_prev;
    assign w_ts_field = c_ts_field_w'(r_ts);
    assign w_entry    = (c_entry_w'(sw_db)      << c_lvl_lsb)
                      | (c_entry_w'(w_rise)     << c_rise_lsb)
                      | (c_entry_w'(w_fall)     << c_fall_lsb)
                      | (c_entry_w'(w_ts_field) << c_ts_lsb);

    // A push lost to a full queue is one that the same-cycle pop cannot make room for.
    assign w_drop    = w_push && w_full && !(pop && evt_valid);
    assign evt_valid = !w_empty;
    assign overflow  = r_overflow;
    assign fabint    = r_fabint;

    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        case (r_state)
            S_PRIME: w_state_next = S_RUN;
            S_RUN:   w_push       = |(sw_db ^ r_sw_prev);
            default: w_state_next = S_PRIME;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_PRIME;
            r_ts       <= '0;
            r_sw_prev  <= '0;
            r_overflow <= 1'b0;
            r_fabint   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_ts      <= r_ts + c_ts_one;
            r_sw_prev <= sw_db;
            if (w_drop)       r_overflow <= 1'b1;
            else if (clr_ovf) r_overflow <= 1'b0;
            r_fabint  <= irq_en && ((evt_count != '0) || r_overflow);
        end
    end

    evt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_entry_w)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .push    (w_push),
        .wr_data (w_entry),
        .pop     (pop),
        .rd_data (evt_data),
        .full    (w_full),
        .empty   (w_empty),
        .count   (evt_count)
    );

endmodule

`default_nettype wire

// File: tb/tb_sw_event_queue.sv
//------------------------------------------------------------------------------
// Module : tb_sw_event_queue
// Brief  : Directed self-checking bench for sw_event_queue (defaults NSW=2,
//          DEPTH=4, TS_W=16). Inputs change and outputs are sampled on negedge.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sw_event_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  sw_db;
    logic        pop;
    logic        clr_ovf;
    logic        irq_en;
    logic        evt_valid;
    logic [31:0] evt_data;
    logic [2:0]  evt_count;
    logic        overflow;
    logic        fabint;

    int          n_vec  = 0;
    int          n_fail = 0;
    logic [15:0] tb_ts;

    always #5 clk = ~clk;

    // Reference timestamp: value the DUT counter holds during the current cycle.
    always @(posedge clk or posedge reset) begin
        if (reset) tb_ts <= 16'h0000;
        else       tb_ts <= tb_ts + 16'h0001;
    end

    sw_event_queue dut (
        .clk       (clk),
        .reset     (reset),
        .sw_db     (sw_db),
        .pop       (pop),
        .clr_ovf   (clr_ovf),
        .irq_en    (irq_en),
        .evt_valid (evt_valid),
        .evt_data  (evt_data),
        .evt_count (evt_count),
        .overflow  (overflow),
        .fabint    (fabint)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ts(input logic [15:0] v);
        bit hit = 1'b0;
        for (int k = 0; k < 70000; k++) begin
            if (tb_ts == v) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        if (!hit) begin
            n_vec++;
            n_fail++;
            $error("FAIL wait_ts: observed timeout expected ts %h", v);
        end
    endtask

    initial begin
        reset   = 1'b1;
        sw_db   = 2'b01;
        pop     = 1'b0;
        clr_ovf = 1'b0;
        irq_en  = 1'b0;
        repeat (2) tick();
        check("rst_valid",    evt_valid, 32'd0);
        check("rst_data",     evt_data,  32'd0);
        check("rst_count",    evt_count, 32'd0);
        check("rst_overflow", overflow,  32'd0);
        check("rst_fabint",   fabint,    32'd0);

        // Level held through reset release must not produce an event.
        reset = 1'b0;
        repeat (5) tick();
        check("prime_count", evt_count, 32'd0);
        check("prime_valid", evt_valid, 32'd0);

        reset = 1'b1;
        sw_db = 2'b00;
        tick();
        reset  = 1'b0;
        irq_en = 1'b1;

        // 00 -> 11 at timestamp 0x0010
        wait_ts(16'h0010);
        sw_db = 2'b11;
        tick();
        check("first_valid",  evt_valid, 32'd1);
        check("first_data",   evt_data,  32'h0010_000F);
        check("first_count",  evt_count, 32'd1);
        check("first_fabint", fabint,    32'd0);
        tick();
        check("first_fabint_late", fabint, 32'd1);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check("pop1_valid", evt_valid, 32'd0);
        check("pop1_data",  evt_data,  32'd0);
        check("pop1_count", evt_count, 32'd0);
        tick();
        check("pop1_fabint", fabint, 32'd0);

        // Five edges at ts 0x40..0x44 into a 4-deep queue
        wait_ts(16'h0040);
        sw_db = 2'b10; tick();
        sw_db = 2'b00; tick();
        sw_db = 2'b01; tick();
        sw_db = 2'b11; tick();
        sw_db = 2'b10; tick();
        check("ovf_count", evt_count, 32'd4);
        check("ovf_flag",  overflow,  32'd1);
        check("ovf_head",  evt_data,  32'h0040_0012);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("clr_flag",  overflow,  32'd0);
        check("clr_count", evt_count, 32'd4);

        // Full queue: push 10->11 and pop together
        wait_ts(16'h0050);
        sw_db = 2'b11;
        pop   = 1'b1;
        tick();
        pop = 1'b0;
        check("fullpp_count", evt_count, 32'd4);
        check("fullpp_ovf",   overflow,  32'd0);
        check("fullpp_head",  evt_data,  32'h0041_0020);
        pop = 1'b1;
        tick(); check("drain_head2", evt_data, 32'h0042_0005);
        tick(); check("drain_head3", evt_data, 32'h0043_000B);
        tick(); check("drain_head4", evt_data, 32'h0050_0007);
        tick(); check("drain_count", evt_count, 32'd0);
        check("drain_data", evt_data, 32'd0);
        tick();
        check("empty_pop_count", evt_count, 32'd0);
        check("empty_pop_valid", evt_valid, 32'd0);
        pop = 1'b0;

        // Overflow and clear in the same cycle: overflow wins
        wait_ts(16'h0060);
        sw_db = 2'b10; tick();
        sw_db = 2'b00; tick();
        sw_db = 2'b01; tick();
        sw_db = 2'b11; tick();
        check("fill_count", evt_count, 32'd4);
        sw_db   = 2'b10;
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("ovf_wins_flag",  overflow,  32'd1);
        check("ovf_wins_count", evt_count, 32'd4);
        check("ovf_wins_head",  evt_data,  32'h0060_0012);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("ovf_cleared", overflow, 32'd0);
        pop = 1'b1;
        repeat (4) tick();
        pop = 1'b0;
        check("drain2_count", evt_count, 32'd0);

        // Timestamp wrap: edges at 0xFFFF, 0x0000 and 0x0001
        wait_ts(16'hFFFF);
        sw_db = 2'b11; tick();
        sw_db = 2'b01; tick();
        check("wrap_count", evt_count, 32'd2);
        check("wrap_head",  evt_data,  32'hFFFF_0007);
        sw_db = 2'b00; tick();
        check("wrap_count3", evt_count, 32'd3);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check("wrap_ts0_head", evt_data,  32'h0000_0021);
        check("wrap_count2",   evt_count, 32'd2);
        wait_ts(16'h0008);
        sw_db = 2'b01;
        tick();
        check("pre_rst_count", evt_count, 32'd3);
        tick();
        check("pre_rst_fabint", fabint, 32'd1);

        // Asynchronous reset with three entries queued
        reset = 1'b1;
        #1;
        check("arst_valid",    evt_valid, 32'd0);
        check("arst_data",     evt_data,  32'd0);
        check("arst_fabint",   fabint,    32'd0);
        check("arst_count",    evt_count, 32'd0);
        check("arst_overflow", overflow,  32'd0);
        tick();
        reset = 1'b0;
        repeat (4) tick();
        check("post_rst_count", evt_count, 32'd0);
        check("post_rst_valid", evt_valid, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sw_event_queue.md
SW_EVENT_QUEUE -- requirements
Module: sw_event_queue

Interface
REQ-001 SHALL have parameter NSW, default 2, number of debounced switch inputs.
REQ-002 SHALL have parameter DEPTH, default 4, event queue entries (power of two).
REQ-003 SHALL have parameter TS_W, default 16, timestamp counter width.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port: clk  in  1  rising-edge clock (the APB PCLK domain).
REQ-006 SHALL have port: reset  in  1  asynchronous active-high reset.
REQ-007 SHALL have port: sw_db  in  NSW  debounced switch levels, synchronous to clk.
REQ-008 SHALL have port: pop  in  1  single-cycle request to remove the head entry.
REQ-009 SHALL have port: clr_ovf  in  1  single-cycle clear of the overflow flag.
REQ-010 SHALL have port: irq_en  in  1  interrupt enable.
REQ-011 SHALL have port: evt_valid  out  1  queue non-empty.
REQ-012 SHALL have port: evt_data  out  32  head entry (show-ahead).
REQ-013 SHALL have port: evt_count  out  log2(DEPTH)+1  occupancy.
REQ-014 SHALL have port: overflow  out  1  sticky event-dropped flag.
REQ-015 SHALL have port: fabint  out  1  registered interrupt to the fabric.

Function
REQ-016 SHALL run a TS_W-bit free-running timestamp counter, +1 every cycle, wrapping from all-ones to 0.
REQ-017 SHALL hold sw_prev, the sw_db value of the previous cycle; edge in cycle N = sw_db != sw_prev.
REQ-018 SHALL use a two-state FSM: PRIME (after reset: load sw_prev from sw_db, generate no event, go to RUN) and RUN (detect edges every cycle).
REQ-019 SHALL merge all edges in one cycle into a single entry: [NSW-1:0] new sw_db level, [NSW+1:2] rising mask, [NSW+3:4] falling mask, [15:8] zero, [31:16] timestamp value during cycle N; unused bits zero.
REQ-020 SHALL write the entry at the end of cycle N; evt_valid and evt_data reflect it from cycle N+1 when the queue was empty.
REQ-021 SHALL drive evt_data to 0 when empty.
REQ-022 SHALL accept a pop only when pop && evt_valid; pop when empty is ignored without error.
REQ-023 SHALL, when full and push without accepted pop, drop the new entry, keep the queue unchanged, and set overflow.
REQ-024 SHALL, when full and push with accepted pop in the same cycle, perform both; count stays DEPTH; overflow unchanged.
REQ-025 SHALL, when empty and push and pop in the same cycle, perform the push only.
REQ-026 SHALL wrap read and write pointers modulo DEPTH.
REQ-027 SHALL clear overflow on clr_ovf; a new overflow in the same cycle wins (overflow stays 1).
REQ-028 SHALL register fabint = irq_en && (evt_count != 0 || overflow), one cycle after the condition.

Reset
REQ-029 SHALL, on reset assertion, asynchronously force: FSM=PRIME, timestamp=0, sw_prev=0, pointers=0, evt_count=0, evt_valid=0, evt_data=0, overflow=0, fabint=0.
REQ-030 SHALL discard queue contents on reset mid-operation; no event is generated for switch levels present at reset release.

Structure
REQ-031 SHALL place entry field offsets/widths, default DEPTH/TS_W/NSW and the FSM state encoding in shared package sw_event_pkg.
REQ-032 SHALL implement storage as one sub-module, evt_fifo (synchronous show-ahead FIFO with push/pop/full/empty/count).

Verification
REQ-033 SHALL cover: sw_db=2'b01 held through reset release -> no entry, evt_count=0 after 5 cycles.
REQ-034 SHALL cover: sw_db 00->11 at timestamp 0x0010 -> next cycle evt_valid=1, evt_data=0x0010_000F, fabint=1 one cycle later with irq_en=1.
REQ-035 SHALL cover: 5 edges, no pops, DEPTH=4 -> evt_count=4, overflow=1, head is first event; clr_ovf -> overflow=0.
REQ-036 SHALL cover: full queue, edge and pop same cycle -> evt_count=4, overflow=0, head advances to second event.
REQ-037 SHALL cover: timestamp 0xFFFF then edge next cycle -> entry timestamp field 0x0000.
REQ-038 SHALL cover: reset asserted with 3 entries queued -> evt_valid, evt_data, fabint=0 immediately, before the next clk edge.
